// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared constants, types and helpers for the PS/2 keyboard
//                receive path.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Prefix bytes that modify the following scan code instead of being queued
    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    // Queued entry layout: {ext, brk, code[7:0]}
    localparam int unsigned PS2_ENTRY_W = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    // A frame is good when the stop bit is high and data+parity carry odd parity
    function automatic logic ps2_frame_ok(input logic [7:0] data,
                                          input logic       parity,
                                          input logic       stop);
        return stop & (^{data, parity});
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock first-word-fall-through FIFO. DEPTH must be a
//                power of two (>= 2); pointers carry one extra wrap bit so
//                full and empty are told apart without a counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             wr_drop_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             w_do_wr;
    logic             w_do_rd;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A write into a full FIFO is only accepted when the head is popped in the same cycle
    assign w_do_wr   = wr_en_i & (~full_o | rd_en_i);
    assign w_do_rd   = rd_en_i & ~empty_o;
    assign wr_drop_o = wr_en_i & full_o & ~rd_en_i;

    // Head entry is visible combinationally while the FIFO is non-empty
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer and storage update
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (w_do_wr) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
                wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
            end
            if (w_do_rd) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_kbd_rx
//  Description : PS/2 keyboard receiver. Synchronises and de-glitches the
//                pins, deframes 11-bit device-to-host frames, folds E0/F0
//                prefixes into flags and queues {ext, brk, code} entries.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50_000,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic       code_ready,
    output logic       code_valid,
    output logic [7:0] code,
    output logic       code_ext,
    output logic       code_brk,
    output logic       err_parity,
    output logic       err_frame,
    output logic       overflow
);

    localparam int unsigned FILT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    // Input conditioning
    logic              clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic [FILT_W-1:0] filt_cnt_q;
    logic              filt_clk_q, filt_clk_prev_q;
    logic              w_edge;

    // Frame receiver
    ps2_state_e        state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              parity_q, parity_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              rx_done_q, rx_done_d;
    logic [7:0]        rx_byte_q, rx_byte_d;
    logic              ext_q, ext_d, brk_q, brk_d;
    logic              err_parity_q, err_parity_d;
    logic              err_frame_q, err_frame_d;
    logic              overflow_q;

    // Queue interface
    logic                   w_push;
    logic [PS2_ENTRY_W-1:0] w_push_data;
    logic [PS2_ENTRY_W-1:0] w_head;
    logic                   w_empty, w_full, w_drop, w_pop;

    // Two-flop synchronisers; idle-high bus so they reset to 1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_dat;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Clock filter: level flips only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_cnt_q      <= '0;
            filt_clk_q      <= 1'b1;
            filt_clk_prev_q <= 1'b1;
        end else begin
            filt_clk_prev_q <= filt_clk_q;
            if (clk_s2_q == filt_clk_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FILT_W'(FILTER_LEN - 1)) begin
                filt_clk_q <= clk_s2_q;
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + FILT_W'(1);
            end
        end
    end

    assign w_edge = filt_clk_prev_q & ~filt_clk_q;

    // Receiver state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            tmo_cnt_q    <= '0;
            rx_done_q    <= 1'b0;
            rx_byte_q    <= '0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            err_parity_q <= 1'b0;
            err_frame_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            tmo_cnt_q    <= tmo_cnt_d;
            rx_done_q    <= rx_done_d;
            rx_byte_q    <= rx_byte_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            err_parity_q <= err_parity_d;
            err_frame_q  <= err_frame_d;
        end
    end

    // Deframing, timeout and prefix decode (decode acts on the byte finished last cycle)
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        tmo_cnt_d    = tmo_cnt_q;
        rx_done_d    = 1'b0;
        rx_byte_d    = rx_byte_q;
        ext_d        = ext_q;
        brk_d        = brk_q;
        err_parity_d = 1'b0;
        err_frame_d  = 1'b0;
        w_push       = 1'b0;
        w_push_data  = {ext_q, brk_q, rx_byte_q};

        if (rx_done_q) begin
            if (rx_byte_q == PS2_PREFIX_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte_q == PS2_PREFIX_BRK) begin
                brk_d = 1'b1;
            end else begin
                w_push = 1'b1;
                ext_d  = 1'b0;
                brk_d  = 1'b0;
            end
        end

        if ((state_q == IDLE) || w_edge) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != TMO_W'(TIMEOUT_CYCLES)) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end

        if ((state_q != IDLE) && !w_edge && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES))) begin
            state_d     = IDLE;
            err_frame_d = 1'b1;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
        end else if (w_edge) begin
            case (state_q)
                IDLE: begin
                    // A high "start bit" is treated as noise and ignored
                    if (!dat_s2_q) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    parity_d = dat_s2_q;
                    state_d  = STOP;
                end
                STOP: begin
                    if (ps2_frame_ok(shift_q, parity_q, dat_s2_q)) begin
                        rx_done_d = 1'b1;
                        rx_byte_d = shift_q;
                    end else begin
                        err_parity_d = 1'b1;
                        ext_d        = 1'b0;
                        brk_d        = 1'b0;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign w_pop = ~w_empty & code_ready;

    sync_fifo #(
        .WIDTH (PS2_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (w_push),
        .wr_data_i (w_push_data),
        .rd_en_i   (w_pop),
        .rd_data_o (w_head),
        .full_o    (w_full),
        .empty_o   (w_empty),
        .wr_drop_o (w_drop)
    );

    // Sticky overflow: set when a decoded entry is lost to a full queue
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (w_drop) begin
            overflow_q <= 1'b1;
        end
    end

    assign code_valid = ~w_empty;
    assign code_ext   = w_head[9];
    assign code_brk   = w_head[8];
    assign code       = w_head[7:0];
    assign err_parity = err_parity_q;
    assign err_frame  = err_frame_q;
    assign overflow   = overflow_q;

    // Full flag is implied by the drop indication; kept for reuse of the FIFO
    logic w_unused;
    assign w_unused = w_full;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_kbd_rx
//  Description : Self-checking bench for ps2_kbd_rx. Drives PS/2 frames at a
//                shortened bit period and compares the decoded stream with a
//                reference model of the keyboard protocol.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_kbd_rx;

    localparam int HALF = 40;     // PS/2 clock half period in system clocks
    localparam int TMO  = 500;    // frame timeout used for this bench
    localparam int GAP  = 120;    // idle time between frames

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       code_ready;
    logic       code_valid;
    logic [7:0] code;
    logic       code_ext;
    logic       code_brk;
    logic       err_parity;
    logic       err_frame;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    // Monitor state (written only by the monitor process)
    logic [9:0] obs_q[$];
    int  perr_cnt  = 0;
    int  ferr_cnt  = 0;
    int  vcyc      = 0;
    int  pulse_bad = 0;
    logic perr_prev = 1'b0;
    logic ferr_prev = 1'b0;

    ps2_kbd_rx #(
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TMO),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .code_ready (code_ready),
        .code_valid (code_valid),
        .code       (code),
        .code_ext   (code_ext),
        .code_brk   (code_brk),
        .err_parity (err_parity),
        .err_frame  (err_frame),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Observe pops, valid cycles and error pulses away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (code_valid && code_ready) obs_q.push_back({code_ext, code_brk, code});
            if (code_valid) vcyc++;
            if (err_parity) perr_cnt++;
            if (err_frame)  ferr_cnt++;
            if ((err_parity && perr_prev) || (err_frame && ferr_prev) || (err_parity && err_frame))
                pulse_bad++;
            perr_prev = err_parity;
            ferr_prev = err_frame;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Device-to-host frame: start 0, data LSB first, odd parity, stop 1
    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad);
        logic par;
        par = ~(^b) ^ bad;
        return {1'b1, par, b, 1'b0};
    endfunction

    // Clock out the first n bits; glitch_bit>=0 adds a 3-cycle low spike while clock is high
    task automatic send_bits(input logic [10:0] bits, input int n, input int glitch_bit);
        for (int i = 0; i < n; i++) begin
            ps2_dat = bits[i];
            if (i == glitch_bit) begin
                wait_cyc(5);
                ps2_clk = 1'b0;
                wait_cyc(3);
                ps2_clk = 1'b1;
                wait_cyc(HALF/2 - 8);
            end else begin
                wait_cyc(HALF/2);
            end
            ps2_clk = 1'b0;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
            wait_cyc(HALF/2);
        end
        ps2_dat = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad, input int glitch_bit);
        send_bits(mk_frame(b, bad), 11, glitch_bit);
        wait_cyc(GAP);
    endtask

    task automatic test_reset;
        rst_n      = 1'b0;
        ps2_clk    = 1'b1;
        ps2_dat    = 1'b1;
        code_ready = 1'b1;
        wait_cyc(5);
        checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", code_valid); end
        checks++; if (code !== 8'h00) begin errors++; $display("FAIL reset_code: got %h expected 00", code); end
        checks++; if ({code_ext, code_brk} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {code_ext, code_brk}); end
        checks++; if ({err_parity, err_frame, overflow} !== 3'b000) begin errors++; $display("FAIL reset_errs: got %b expected 000", {err_parity, err_frame, overflow}); end
        rst_n = 1'b1;
        wait_cyc(5);
    endtask

    task automatic test_single;
        int b, v, p, f;
        b = obs_q.size(); v = vcyc; p = perr_cnt; f = ferr_cnt;
        send_frame(8'h1C, 1'b0, -1);
        checks++; if (obs_q.size() - b !== 1) begin errors++; $display("FAIL single_count: got %0d expected 1", obs_q.size() - b); end
        else begin
            checks++; if (obs_q[b] !== 10'h01C) begin errors++; $display("FAIL single_entry: got %h expected 01c", obs_q[b]); end
        end
        checks++; if (vcyc - v !== 1) begin errors++; $display("FAIL single_valid_cycles: got %0d expected 1", vcyc - v); end
        checks++; if ((perr_cnt - p) + (ferr_cnt - f) !== 0) begin errors++; $display("FAIL single_errs: got %0d expected 0", (perr_cnt - p) + (ferr_cnt - f)); end
    endtask

    task automatic test_prefix;
        int b;
        b = obs_q.size();
        send_frame(8'hF0, 1'b0, -1);
        send_frame(8'h1C, 1'b0, -1);
        send_frame(8'hE0, 1'b0, -1);
        send_frame(8'hF0, 1'b0, -1);
        send_frame(8'h75, 1'b0, -1);
        checks++; if (obs_q.size() - b !== 2) begin errors++; $display("FAIL prefix_count: got %0d expected 2", obs_q.size() - b); end
        else begin
            checks++; if (obs_q[b] !== {2'b01, 8'h1C}) begin errors++; $display("FAIL prefix_brk: got %h expected 11c", obs_q[b]); end
            checks++; if (obs_q[b+1] !== {2'b11, 8'h75}) begin errors++; $display("FAIL prefix_ext_brk: got %h expected 375", obs_q[b+1]); end
        end
    endtask

    task automatic test_parity_error;
        int b, p;
        b = obs_q.size(); p = perr_cnt;
        send_frame(8'hE0, 1'b0, -1);
        send_frame(8'h1C, 1'b1, -1);
        checks++; if (perr_cnt - p !== 1) begin errors++; $display("FAIL parity_pulse: got %0d expected 1", perr_cnt - p); end
        checks++; if (obs_q.size() - b !== 0) begin errors++; $display("FAIL parity_no_entry: got %0d expected 0", obs_q.size() - b); end
        send_frame(8'h1C, 1'b0, -1);
        checks++; if (obs_q.size() - b !== 1) begin errors++; $display("FAIL parity_recover_count: got %0d expected 1", obs_q.size() - b); end
        else begin
            checks++; if (obs_q[b] !== 10'h01C) begin errors++; $display("FAIL parity_flag_cleared: got %h expected 01c", obs_q[b]); end
        end
    endtask

    task automatic test_overflow;
        logic [7:0] seq [5];
        int b;
        seq[0] = 8'h1C; seq[1] = 8'h32; seq[2] = 8'h21; seq[3] = 8'h23; seq[4] = 8'h2B;
        code_ready = 1'b0;
        b = obs_q.size();
        for (int i = 0; i < 4; i++) send_frame(seq[i], 1'b0, -1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_before: got %b expected 0", overflow); end
        checks++; if ({code_valid, code_ext, code_brk, code} !== {1'b1, 2'b00, 8'h1C}) begin
            errors++; $display("FAIL ovf_head: got %b/%h expected 1/01c", code_valid, {code_ext, code_brk, code}); end
        send_frame(seq[4], 1'b0, -1);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        code_ready = 1'b1;
        wait_cyc(20);
        checks++; if (obs_q.size() - b !== 4) begin errors++; $display("FAIL ovf_drain_count: got %0d expected 4", obs_q.size() - b); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_q[b+i] !== {2'b00, seq[i]}) begin errors++; $display("FAIL ovf_order[%0d]: got %h expected %h", i, obs_q[b+i], {2'b00, seq[i]}); end
            end
        end
        checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b expected 0", code_valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
        rst_n = 1'b0;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(3);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_reset: got %b expected 0", overflow); end
    endtask

    task automatic test_timeout;
        int b, f;
        b = obs_q.size(); f = ferr_cnt;
        send_frame(8'hE0, 1'b0, -1);
        send_bits(mk_frame(8'h1C, 1'b0), 5, -1);
        wait_cyc(2 * TMO);
        checks++; if (ferr_cnt - f !== 1) begin errors++; $display("FAIL timeout_pulse: got %0d expected 1", ferr_cnt - f); end
        checks++; if (obs_q.size() - b !== 0) begin errors++; $display("FAIL timeout_no_entry: got %0d expected 0", obs_q.size() - b); end
        send_frame(8'h29, 1'b0, -1);
        checks++; if (obs_q.size() - b !== 1) begin errors++; $display("FAIL timeout_recover_count: got %0d expected 1", obs_q.size() - b); end
        else begin
            checks++; if (obs_q[b] !== 10'h029) begin errors++; $display("FAIL timeout_recover: got %h expected 029", obs_q[b]); end
        end
    endtask

    task automatic test_reset_midframe;
        int b, p, f;
        send_bits(mk_frame(8'h77, 1'b0), 4, -1);
        rst_n = 1'b0;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(5);
        b = obs_q.size(); p = perr_cnt; f = ferr_cnt;
        send_frame(8'h5A, 1'b0, -1);
        checks++; if (obs_q.size() - b !== 1) begin errors++; $display("FAIL midreset_count: got %0d expected 1", obs_q.size() - b); end
        else begin
            checks++; if (obs_q[b] !== 10'h05A) begin errors++; $display("FAIL midreset_entry: got %h expected 05a", obs_q[b]); end
        end
        checks++; if ((perr_cnt - p) + (ferr_cnt - f) !== 0) begin errors++; $display("FAIL midreset_errs: got %0d expected 0", (perr_cnt - p) + (ferr_cnt - f)); end
    endtask

    task automatic test_glitch;
        int b, p, f;
        b = obs_q.size(); p = perr_cnt; f = ferr_cnt;
        // Spike in idle with data low: would look like a start bit if accepted
        ps2_dat = 1'b0;
        wait_cyc(2);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(2);
        ps2_dat = 1'b1;
        wait_cyc(100);
        send_frame(8'h34, 1'b0, 4);
        checks++; if (obs_q.size() - b !== 1) begin errors++; $display("FAIL glitch_count: got %0d expected 1", obs_q.size() - b); end
        else begin
            checks++; if (obs_q[b] !== 10'h034) begin errors++; $display("FAIL glitch_entry: got %h expected 034", obs_q[b]); end
        end
        checks++; if ((perr_cnt - p) + (ferr_cnt - f) !== 0) begin errors++; $display("FAIL glitch_errs: got %0d expected 0", (perr_cnt - p) + (ferr_cnt - f)); end
    endtask

    // Random prefixes, codes and parity faults against a protocol-level model
    task automatic test_random;
        logic [9:0] exp_q[$];
        logic       m_ext, m_brk;
        int         m_perr, b, p, f;
        bit         done;
        m_ext = 1'b0; m_brk = 1'b0; m_perr = 0; done = 1'b0;
        b = obs_q.size(); p = perr_cnt; f = ferr_cnt;
        fork
            begin
                for (int n = 0; n < 25; n++) begin
                    logic [7:0] byt;
                    bit         bad;
                    int         sel;
                    sel = $urandom_range(0, 9);
                    if (sel < 2)      byt = 8'hE0;
                    else if (sel < 4) byt = 8'hF0;
                    else begin
                        byt = 8'($urandom_range(0, 255));
                        if (byt == 8'hE0 || byt == 8'hF0) byt = 8'h66;
                    end
                    bad = ($urandom_range(0, 7) == 0);
                    if (bad) begin
                        m_perr++; m_ext = 1'b0; m_brk = 1'b0;
                    end else if (byt == 8'hE0) m_ext = 1'b1;
                    else if (byt == 8'hF0)     m_brk = 1'b1;
                    else begin
                        exp_q.push_back({m_ext, m_brk, byt});
                        m_ext = 1'b0; m_brk = 1'b0;
                    end
                    send_frame(byt, bad, -1);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    code_ready = 1'($urandom_range(0, 1));
                    wait_cyc(1);
                end
                code_ready = 1'b1;
            end
        join
        wait_cyc(20);
        checks++; if (obs_q.size() - b !== exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", obs_q.size() - b, exp_q.size()); end
        else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[b+i] !== exp_q[i]) begin errors++; $display("FAIL rand_entry[%0d]: got %h expected %h", i, obs_q[b+i], exp_q[i]); end
            end
        end
        checks++; if (perr_cnt - p !== m_perr) begin errors++; $display("FAIL rand_parity_errs: got %0d expected %0d", perr_cnt - p, m_perr); end
        checks++; if (ferr_cnt - f !== 0) begin errors++; $display("FAIL rand_frame_errs: got %0d expected 0", ferr_cnt - f); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rand_overflow: got %b expected 0", overflow); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_prefix();
        test_parity_error();
        test_overflow();
        test_timeout();
        test_reset_midframe();
        test_glitch();
        test_random();
        checks++; if (pulse_bad !== 0) begin errors++; $display("FAIL error_pulse_shape: got %0d expected 0", pulse_bad); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
